pht_ctrl: RTL and testbench

Controller for a bimodal pattern history table (PHT) of 2^IDX_W two-bit saturating counters, held in internal registers.
- Shares the single table read port between the fetch-side lookup path and the resolve-side training path.
- Sequences read-modify-write updates with forwarding between them.
- Runs an initialisation sweep after reset or flush.
- Sits between the fetch predictor front-end and the branch-resolution unit.

---
 rtl/pht_ctrl.sv | 130 +++++++++++++
 tb/tb_pht_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pht_ctrl.sv
// Bimodal PHT controller: 2^IDX_W two-bit counters with one shared read port
// arbitrated between fetch lookups and resolve-side training, plus init sweep.
module pht_ctrl #(
  parameter int          IDX_W      = 6,
  parameter logic [1:0]  INIT_CTR   = 2'b01,
  parameter int          STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             resp_valid,
  output logic [1:0]       resp_ctr,
  output logic             resp_taken,
  input  logic             train_valid,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken,
  output logic             train_ready,
  output logic             busy
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_init_idx;
  logic [1:0]       r_tbl [DEPTH];

  logic             r_pend_valid;
  logic [IDX_W-1:0] r_pend_idx;
  logic             r_pend_taken;
  logic [SW-1:0]    r_starve_cnt;

  logic             r_w_valid;
  logic [IDX_W-1:0] r_w_idx;
  logic [1:0]       r_w_new;

  logic             r_resp_valid;
  logic [1:0]       r_resp_ctr;

  logic             w_run, w_starved, w_lk_grant, w_pend_grant, w_train_acc;
  logic [IDX_W-1:0] w_rd_idx;
  logic [1:0]       w_rd_val, w_new;

  assign w_run        = (r_state == S_RUN);
  assign w_starved    = r_pend_valid && (r_starve_cnt == SW'(STARVE_MAX));
  assign lookup_ready = w_run && !w_starved;
  assign w_lk_grant   = lookup_valid && lookup_ready;
  assign w_pend_grant = w_run && r_pend_valid && !w_lk_grant;
  assign train_ready  = w_run && (!r_pend_valid || w_pend_grant);
  assign w_train_acc  = train_valid && train_ready;
  assign busy         = (r_state == S_INIT);
  assign resp_valid   = r_resp_valid;
  assign resp_ctr     = r_resp_ctr;
  assign resp_taken   = r_resp_ctr[1];

  // Single read port; an in-flight W write is forwarded so RMW chains stay exact.
  assign w_rd_idx = w_lk_grant ? lookup_idx : r_pend_idx;
  assign w_rd_val = (r_w_valid && (r_w_idx == w_rd_idx)) ? r_w_new : r_tbl[w_rd_idx];

  always_comb begin
    w_new = w_rd_val;
    if (r_pend_taken) begin
      if (w_rd_val != 2'b11) w_new = w_rd_val + 2'b01;
    end else begin
      if (w_rd_val != 2'b00) w_new = w_rd_val - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state      <= S_INIT;
      r_init_idx   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_taken <= 1'b0;
      r_starve_cnt <= '0;
      r_w_valid    <= 1'b0;
      r_w_idx      <= '0;
      r_w_new      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_ctr   <= '0;
    end else begin
      r_resp_valid <= w_lk_grant;
      if (w_lk_grant) r_resp_ctr <= w_rd_val;

      r_w_valid <= w_pend_grant && !flush;
      if (w_pend_grant) begin
        r_w_idx <= r_pend_idx;
        r_w_new <= w_new;
      end

      if (flush) begin
        r_state      <= S_INIT;
        r_init_idx   <= '0;
        r_pend_valid <= 1'b0;
        r_starve_cnt <= '0;
      end else begin
        if (r_state == S_INIT) begin
          r_init_idx <= r_init_idx + 1'b1;
          if (r_init_idx == {IDX_W{1'b1}}) r_state <= S_RUN;
        end

        if (w_train_acc) begin
          r_pend_valid <= 1'b1;
          r_pend_idx   <= train_idx;
          r_pend_taken <= train_taken;
        end else if (w_pend_grant) begin
          r_pend_valid <= 1'b0;
        end

        if (w_pend_grant)
          r_starve_cnt <= '0;
        else if (r_pend_valid && r_starve_cnt != SW'(STARVE_MAX))
          r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  // Table storage needs no reset: the init sweep defines every entry.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT && !flush)
      r_tbl[r_init_idx] <= INIT_CTR;
    else if (r_w_valid && w_run && !flush)
      r_tbl[r_w_idx] <= r_w_new;
  end
endmodule

// File: tb/tb_pht_ctrl.sv
// Bench for pht_ctrl: vector table of trains/lookups plus hand-written corner
// sequences; lookup responses are checked through an expected-value queue.
module tb_pht_ctrl;
  logic       clk, areset, flush;
  logic       lookup_valid, lookup_ready, resp_valid, resp_taken;
  logic [5:0] lookup_idx, train_idx;
  logic [1:0] resp_ctr;
  logic       train_valid, train_taken, train_ready, busy;

  pht_ctrl #(.IDX_W(6), .INIT_CTR(2'b01), .STARVE_MAX(4)) dut (
    .clk(clk), .areset(areset), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
    .resp_valid(resp_valid), .resp_ctr(resp_ctr), .resp_taken(resp_taken),
    .train_valid(train_valid), .train_idx(train_idx), .train_taken(train_taken),
    .train_ready(train_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Response monitor: every resp_valid pops one expected counter value.
  always @(negedge clk) begin
    if (!areset && resp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got ctr %0d expected no response", resp_ctr);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (resp_ctr != e || resp_taken != e[1]) begin
          fails++;
          $display("FAIL resp_ctr: got %0d/%0d expected %0d/%0d", resp_ctr, resp_taken, e, e[1]);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_lookup(input logic [5:0] idx, input logic [1:0] exp);
    logic got;
    got = 1'b0;
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = lookup_ready;
      if (got) exp_q.push_back(exp);
      @(posedge clk); #1;
    end
    lookup_valid = 1'b0;
    if (!got) chk("lookup_timeout", 0, 1);
  endtask

  task automatic do_train(input logic [5:0] idx, input logic tk);
    logic got;
    got = 1'b0;
    train_valid = 1'b1;
    train_idx   = idx;
    train_taken = tk;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = train_ready;
      @(posedge clk); #1;
    end
    train_valid = 1'b0;
    if (!got) chk("train_timeout", 0, 1);
  endtask

  // Counts busy cycles from now and checks both readies stay low meanwhile.
  task automatic sweep_check(input string name);
    int cnt, rdy;
    cnt = 0;
    rdy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (lookup_ready || train_ready) rdy++;
    end
    chk({name, "_busy_cycles"}, cnt, 64);
    chk({name, "_ready_in_init"}, rdy, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       is_train;
    logic [5:0] idx;
    logic       taken;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t tv(input logic [5:0] idx, input logic tk);
    vec_t v;
    v.is_train = 1'b1; v.idx = idx; v.taken = tk; v.exp = 2'b00;
    return v;
  endfunction

  function automatic vec_t lv(input logic [5:0] idx, input logic [1:0] e);
    vec_t v;
    v.is_train = 1'b0; v.idx = idx; v.taken = 1'b0; v.exp = e;
    return v;
  endfunction

  initial begin
    areset = 1'b1; flush = 1'b0;
    lookup_valid = 1'b0; lookup_idx = '0;
    train_valid = 1'b0; train_idx = '0; train_taken = 1'b0;
    #2;
    chk("rst_busy", busy, 1);
    chk("rst_lookup_ready", lookup_ready, 0);
    chk("rst_train_ready", train_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_ctr", resp_ctr, 0);
    @(posedge clk); #1;
    areset = 1'b0;
    sweep_check("init");
    for (int i = 0; i < 64; i++) do_lookup(6'(i), 2'b01);

    // Saturation on idx 5, back-to-back trains on 7 (forwarded), misc entries.
    vecs.push_back(tv(5, 1)); vecs.push_back(tv(5, 1)); vecs.push_back(tv(5, 1));
    vecs.push_back(lv(5, 3));
    vecs.push_back(tv(5, 1)); vecs.push_back(lv(5, 3));
    vecs.push_back(tv(5, 0)); vecs.push_back(lv(5, 2));
    vecs.push_back(tv(5, 0)); vecs.push_back(lv(5, 1));
    vecs.push_back(tv(5, 0)); vecs.push_back(lv(5, 0));
    vecs.push_back(tv(5, 0)); vecs.push_back(lv(5, 0));
    vecs.push_back(tv(7, 1)); vecs.push_back(tv(7, 1)); vecs.push_back(lv(7, 3));
    vecs.push_back(tv(20, 0)); vecs.push_back(lv(20, 0));
    vecs.push_back(tv(40, 1)); vecs.push_back(tv(40, 0)); vecs.push_back(lv(40, 1));
    foreach (vecs[i]) begin
      if (vecs[i].is_train) do_train(vecs[i].idx, vecs[i].taken);
      else begin
        idle(2);
        do_lookup(vecs[i].idx, vecs[i].exp);
      end
    end
    idle(3);

    // Lookup lands in the W cycle of a train to the same entry.
    do_train(3, 1);
    idle(1);
    do_lookup(3, 2'b10);
    idle(3);

    // Starvation: lookup held valid while one train waits.
    lookup_valid = 1'b1; lookup_idx = 10;
    train_valid = 1'b1; train_idx = 11; train_taken = 1'b1;
    @(negedge clk);
    chk("starve_train_acc", train_ready, 1);
    if (lookup_ready) exp_q.push_back(2'b01);
    @(posedge clk); #1;
    train_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("starve_denied_lookup_ready", lookup_ready, 1);
      chk("starve_denied_train_ready", train_ready, 0);
      if (lookup_ready) exp_q.push_back(2'b01);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("starve_override_lookup_ready", lookup_ready, 0);
    chk("starve_override_train_ready", train_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("starve_after_lookup_ready", lookup_ready, 1);
    if (lookup_ready) exp_q.push_back(2'b01);
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    idle(2);
    do_lookup(11, 2'b10);
    idle(3);

    // Flush while the train to idx 9 is about to enter W.
    do_train(9, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sweep_check("flush");
    do_lookup(9, 2'b01);
    do_lookup(5, 2'b01);
    idle(3);

    // Async reset between edges with a train held pending behind lookups.
    lookup_valid = 1'b1; lookup_idx = 12;
    train_valid = 1'b1; train_idx = 13; train_taken = 1'b1;
    @(negedge clk);
    if (lookup_ready) exp_q.push_back(2'b01);
    @(posedge clk); #1;
    train_valid = 1'b0;
    @(negedge clk);
    if (lookup_ready) exp_q.push_back(2'b01);
    #2;
    areset = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_busy", busy, 1);
    chk("arst_lookup_ready", lookup_ready, 0);
    chk("arst_train_ready", train_ready, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_ctr", resp_ctr, 0);
    lookup_valid = 1'b0;
    @(posedge clk); #1;
    areset = 1'b0;
    sweep_check("arst");
    for (int i = 0; i < 64; i++) do_lookup(6'(i), 2'b01);
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
